// File: rtl/mmu_tlb.sv
// Sv39 MMU front end: bare pass-through, TLB lookup, 3-level page walk.
// Define MMU_TLB_EN to build the fully-associative TLB; otherwise every translation walks.
package mmu_tlb_pkg;
    typedef logic [1:0] u2;
    localparam u2 PRIV_U = 2'd0;
    localparam u2 PRIV_S = 2'd1;
    localparam u2 PRIV_M = 2'd3;

    typedef logic [2:0] msize_t;
    localparam msize_t MSIZE8 = 3'd3;
    typedef logic [3:0] mlen_t;
    localparam mlen_t MLEN1 = 4'd0;
    typedef logic [1:0] axi_burst_t;
    localparam axi_burst_t AXI_BURST_FIXED = 2'd0;
    localparam axi_burst_t AXI_BURST_INCR = 2'd1;

    typedef struct packed {
        logic [3:0]  mode;
        logic [15:0] asid;
        logic [43:0] ppn;
    } satp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
        axi_burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module mmu_tlb
    import mmu_tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  satp_t      satp,
    input  u2          priviledgeMode,
    input  logic       sfence,
    input  cbus_req_t  ireq,
    output cbus_resp_t iresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp,
    output logic       page_fault,
    output logic       tlb_hit
);
    typedef enum logic [2:0] {
        IDLE, PTW_L2, PTW_L1, PTW_L0, ACCESS, RESP, FAULT
    } state_t;

    state_t state, state_n;

    cbus_req_t  oreq_n;
    cbus_resp_t iresp_n;
    logic       fault_n;
    logic       hit_n;

    logic [26:0] vpn;
    logic        bare;
    logic        beat;
    logic        in_walk;
    logic [1:0]  walk_lvl;
    logic [8:0]  next_idx;
    logic [63:0] pte;
    logic [43:0] pte_ppn;
    logic        pte_leaf;
    logic        pte_fault;

    logic        hit;
    logic [43:0] hit_ppn;
    logic [1:0]  hit_lvl;

    function automatic logic [63:0] phys_addr(
        input logic [43:0] ppn,
        input logic [1:0]  lvl,
        input logic [63:0] va
    );
        case (lvl)
            2'd2:    phys_addr = {8'b0, ppn[43:18], va[29:0]};
            2'd1:    phys_addr = {8'b0, ppn[43:9], va[20:0]};
            default: phys_addr = {8'b0, ppn, va[11:0]};
        endcase
    endfunction

    function automatic cbus_req_t pte_req(
        input logic [43:0] ppn,
        input logic [8:0]  idx
    );
        cbus_req_t r;
        r = '0;
        r.valid = 1'b1;
        r.size = MSIZE8;
        r.addr = {8'b0, ppn, 12'b0} + {52'b0, idx, 3'b0};
        r.len = MLEN1;
        r.burst = AXI_BURST_FIXED;
        return r;
    endfunction

    assign vpn = ireq.addr[38:12];
    assign bare = !ireq.addr[31]
        || priviledgeMode == PRIV_M
        || satp.mode == 4'd0;
    assign beat = oresp.ready && oresp.last;
    assign in_walk = state == PTW_L2
        || state == PTW_L1
        || state == PTW_L0;

    always_comb begin
        case (state)
            PTW_L2:  walk_lvl = 2'd2;
            PTW_L1:  walk_lvl = 2'd1;
            default: walk_lvl = 2'd0;
        endcase
    end

    assign next_idx = walk_lvl == 2'd2 ? vpn[17:9] : vpn[8:0];

    // PTE layout: V=0 R=1 W=2 X=3, ppn in [53:10]
    assign pte = oresp.data;
    assign pte_ppn = pte[53:10];
    assign pte_leaf = pte[1] | pte[2] | pte[3];
    assign pte_fault = !pte[0]
        || (!pte[1] && pte[2])
        || (!pte_leaf && walk_lvl == 2'd0)
        || (pte_leaf && walk_lvl == 2'd2 && pte_ppn[17:0] != '0)
        || (pte_leaf && walk_lvl == 2'd1 && pte_ppn[8:0] != '0);

    logic unused_bits;
    assign unused_bits = ^{satp.asid, pte[63:54], pte[9:4]};

`ifdef MMU_TLB_EN
    localparam int IW = $clog2(TLB_ENTRIES);

    logic [TLB_ENTRIES-1:0] tlb_v;
    logic [26:0]            tlb_vpn [TLB_ENTRIES];
    logic [43:0]            tlb_ppn [TLB_ENTRIES];
    logic [1:0]             tlb_lvl [TLB_ENTRIES];
    logic [IW-1:0]          rr;
    logic                   refill;

    assign refill = in_walk && beat && !pte_fault && pte_leaf;

    // superpage entries only compare the upper VPN fields
    always_comb begin
        logic [26:0] mask;
        hit = 1'b0;
        hit_ppn = '0;
        hit_lvl = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            case (tlb_lvl[i])
                2'd2:    mask = 27'h7FC_0000;
                2'd1:    mask = 27'h7FF_FE00;
                default: mask = 27'h7FF_FFFF;
            endcase
            if (!hit && tlb_v[i] && ((vpn ^ tlb_vpn[i]) & mask) == '0) begin
                hit = 1'b1;
                hit_ppn = tlb_ppn[i];
                hit_lvl = tlb_lvl[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tlb_v <= '0;
            rr <= '0;
        end else if (sfence) begin
            tlb_v <= '0;
        end else if (refill) begin
            tlb_v[rr] <= 1'b1;
            rr <= (rr == IW'(TLB_ENTRIES - 1)) ? '0 : rr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (refill && !sfence) begin
            tlb_vpn[rr] <= vpn;
            tlb_ppn[rr] <= pte_ppn;
            tlb_lvl[rr] <= walk_lvl;
        end
    end
`else
    assign hit = 1'b0;
    assign hit_ppn = '0;
    assign hit_lvl = '0;

    logic        unused_sfence;
    logic [31:0] unused_entries;
    assign unused_sfence = sfence;
    assign unused_entries = 32'(TLB_ENTRIES);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (ireq.valid)
                    state_n = (bare || hit) ? ACCESS : PTW_L2;
            end
            PTW_L2, PTW_L1, PTW_L0: begin
                if (beat) begin
                    if (pte_fault)         state_n = FAULT;
                    else if (pte_leaf)     state_n = ACCESS;
                    else if (state == PTW_L2) state_n = PTW_L1;
                    else                   state_n = PTW_L0;
                end
            end
            ACCESS:  if (beat) state_n = RESP;
            RESP:    state_n = IDLE;
            FAULT:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        oreq_n = oreq;
        iresp_n = '0;
        fault_n = 1'b0;
        hit_n = 1'b0;
        case (state)
            IDLE: begin
                if (ireq.valid) begin
                    if (bare) begin
                        oreq_n = ireq;
                        oreq_n.valid = 1'b1;
                    end else if (hit) begin
                        hit_n = 1'b1;
                        oreq_n = ireq;
                        oreq_n.valid = 1'b1;
                        oreq_n.addr = phys_addr(hit_ppn, hit_lvl, ireq.addr);
                    end else begin
                        oreq_n = pte_req(satp.ppn, vpn[26:18]);
                    end
                end
            end
            PTW_L2, PTW_L1, PTW_L0: begin
                if (beat) begin
                    if (pte_fault) begin
                        oreq_n = '0;
                        iresp_n.ready = 1'b1;
                        iresp_n.last = 1'b1;
                        fault_n = 1'b1;
                    end else if (pte_leaf) begin
                        oreq_n = ireq;
                        oreq_n.valid = 1'b1;
                        oreq_n.addr = phys_addr(pte_ppn, walk_lvl, ireq.addr);
                    end else begin
                        oreq_n = pte_req(pte_ppn, next_idx);
                    end
                end
            end
            ACCESS: begin
                if (beat) begin
                    oreq_n = '0;
                    iresp_n.ready = 1'b1;
                    iresp_n.last = 1'b1;
                    iresp_n.data = oresp.data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oreq <= '0;
            iresp <= '0;
            page_fault <= 1'b0;
            tlb_hit <= 1'b0;
        end else begin
            oreq <= oreq_n;
            iresp <= iresp_n;
            page_fault <= fault_n;
            tlb_hit <= hit_n;
        end
    end
endmodule

// File: tb/tb_mmu_tlb.sv
// Directed bench for mmu_tlb: bare path, Sv39 walks, TLB hits, sfence, faults.
// Expectations for TLB behaviour follow whether MMU_TLB_EN is defined.
module tb_mmu_tlb;
    import mmu_tlb_pkg::*;

    localparam logic [63:0] K      = 64'h5A5A_0000_0000_5A5A;
    localparam logic [63:0] VA1    = 64'hFFFF_FFC0_8000_0123;
    localparam logic [63:0] VA_BAD = 64'hFFFF_FFC0_C000_0000;
    localparam logic [63:0] PAGE0  = 64'hFFFF_FFC0_8000_0000;
`ifdef MMU_TLB_EN
    localparam bit TLB_ON = 1'b1;
`else
    localparam bit TLB_ON = 1'b0;
`endif

    logic       clk;
    logic       reset;
    satp_t      satp;
    u2          priv_mode;
    logic       sfence;
    cbus_req_t  ireq;
    cbus_resp_t iresp;
    cbus_req_t  oreq;
    cbus_resp_t oresp;
    logic       page_fault;
    logic       tlb_hit;

    mmu_tlb #(.TLB_ENTRIES(8)) dut (
        .clk(clk),
        .reset(reset),
        .satp(satp),
        .priviledgeMode(priv_mode),
        .sfence(sfence),
        .ireq(ireq),
        .iresp(iresp),
        .oreq(oreq),
        .oresp(oresp),
        .page_fault(page_fault),
        .tlb_hit(tlb_hit)
    );

    int n_checks;
    int n_fail;
    int pte_reads;
    int data_reads;
    logic [63:0] last_data_addr;

    cbus_req_t   r_req1;
    logic        r_hit;
    int          r_hit_cycles;
    logic        r_fault;
    logic [63:0] r_data;
    logic        r_ready_after;
    logic        r_pf_after;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // page tables: root 0x80100, VPN2 0x102 -> 0x80101 -> 0x80102 (9 leaves)
    function automatic logic [63:0] pte_mem(input logic [63:0] a);
        logic [63:0] off;
        off = a - 64'h8010_2000;
        if (a == 64'h8010_0810) return {10'b0, 44'h80101, 10'h001};
        if (a == 64'h8010_0818) return {10'b0, 44'h80103, 10'h001};
        if (a == 64'h8010_1000) return {10'b0, 44'h80102, 10'h001};
        if (a >= 64'h8010_2000 && off < 64'd72 && off[2:0] == 3'd0)
            return {10'b0, 44'h80200 + {41'b0, off[5:3]} + {40'b0, off[6], 3'b0}, 10'h00F};
        return 64'h0;
    endfunction

    initial begin
        oresp = '0;
        forever begin
            @(posedge clk);
            #1;
            if (oresp.ready) begin
                oresp = '0;
            end else if (oreq.valid) begin
                if (oreq.addr >= 64'h8010_0000 && oreq.addr < 64'h8011_0000) begin
                    pte_reads++;
                    oresp.data = pte_mem(oreq.addr);
                end else begin
                    data_reads++;
                    last_data_addr = oreq.addr;
                    oresp.data = oreq.addr ^ K;
                end
                oresp.ready = 1'b1;
                oresp.last = 1'b1;
            end
        end
    end

    task automatic do_req(input logic [63:0] va, input u2 priv);
        int n;
        priv_mode = priv;
        @(posedge clk);
        #1;
        pte_reads = 0;
        data_reads = 0;
        last_data_addr = '0;
        r_hit_cycles = 0;
        ireq = '0;
        ireq.valid = 1'b1;
        ireq.addr = va;
        ireq.size = MSIZE8;
        ireq.len = MLEN1;
        ireq.burst = AXI_BURST_FIXED;
        @(posedge clk);
        #1;
        r_req1 = oreq;
        r_hit = tlb_hit;
        if (tlb_hit) r_hit_cycles++;
        n = 0;
        while (!iresp.ready && n < 80) begin
            @(posedge clk);
            #1;
            n++;
            if (tlb_hit) r_hit_cycles++;
        end
        if (!iresp.ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_timeout va=%h no iresp.ready within 80 cycles", va);
        end
        r_fault = page_fault;
        r_data = iresp.data;
        ireq.valid = 1'b0;
        @(posedge clk);
        #1;
        r_ready_after = iresp.ready;
        r_pf_after = page_fault;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        n_checks++;
        if (oreq !== '0) begin
            n_fail++;
            $display("FAIL reset_oreq got %h want 0", oreq);
        end
        n_checks++;
        if (iresp !== '0) begin
            n_fail++;
            $display("FAIL reset_iresp got %h want 0", iresp);
        end
        n_checks++;
        if ({page_fault, tlb_hit} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 00", {page_fault, tlb_hit});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_bare();
        do_req(64'h8000_1000, PRIV_M);
        n_checks++;
        if (r_req1.valid !== 1'b1 || r_req1.addr !== 64'h8000_1000) begin
            n_fail++;
            $display("FAIL bare_m_oreq got v=%b a=%h want v=1 a=%h",
                     r_req1.valid, r_req1.addr, 64'h8000_1000);
        end
        n_checks++;
        if (pte_reads !== 0 || data_reads !== 1) begin
            n_fail++;
            $display("FAIL bare_m_reads got pte=%0d data=%0d want 0/1", pte_reads, data_reads);
        end
        n_checks++;
        if (r_data !== (64'h8000_1000 ^ K) || r_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL bare_m_data got %h pf=%b want %h pf=0", r_data, r_fault,
                     64'h8000_1000 ^ K);
        end
        n_checks++;
        if (r_ready_after !== 1'b0) begin
            n_fail++;
            $display("FAIL bare_m_ready_width got %b want 0 next cycle", r_ready_after);
        end
        do_req(64'h0000_0000_0000_1000, PRIV_S);
        n_checks++;
        if (r_req1.addr !== 64'h1000 || pte_reads !== 0) begin
            n_fail++;
            $display("FAIL bare_low_addr got a=%h pte=%0d want 1000/0", r_req1.addr, pte_reads);
        end
        satp.mode = 4'd0;
        do_req(VA1, PRIV_S);
        satp.mode = 4'd8;
        n_checks++;
        if (r_req1.addr !== VA1 || pte_reads !== 0 || r_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL bare_mode0 got a=%h pte=%0d hit=%b want %h/0/0",
                     r_req1.addr, pte_reads, r_hit, VA1);
        end
    endtask

    // bit 31 of the VA is set so the request is translated
    task automatic test_cold_walk();
        do_req(VA1, PRIV_S);
        n_checks++;
        if (r_req1.valid !== 1'b1 || r_req1.addr !== 64'h8010_0810) begin
            n_fail++;
            $display("FAIL walk_l2_req got v=%b a=%h want v=1 a=80100810",
                     r_req1.valid, r_req1.addr);
        end
        n_checks++;
        if (r_req1.size !== MSIZE8 || r_req1.len !== MLEN1
            || r_req1.burst !== AXI_BURST_FIXED || r_req1.is_write !== 1'b0) begin
            n_fail++;
            $display("FAIL walk_req_shape got size=%0d len=%0d burst=%0d wr=%b want 3/0/0/0",
                     r_req1.size, r_req1.len, r_req1.burst, r_req1.is_write);
        end
        n_checks++;
        if (pte_reads !== 3 || last_data_addr !== 64'h8020_0123) begin
            n_fail++;
            $display("FAIL walk_result got pte=%0d pa=%h want 3/80200123",
                     pte_reads, last_data_addr);
        end
        n_checks++;
        if (r_data !== (64'h8020_0123 ^ K) || r_fault !== 1'b0 || r_hit_cycles !== 0) begin
            n_fail++;
            $display("FAIL walk_resp got d=%h pf=%b hits=%0d want %h/0/0",
                     r_data, r_fault, r_hit_cycles, 64'h8020_0123 ^ K);
        end
    endtask

    task automatic test_tlb_hit();
        do_req(VA1, PRIV_S);
        n_checks++;
        if (r_hit !== TLB_ON || r_hit_cycles !== int'(TLB_ON)) begin
            n_fail++;
            $display("FAIL hit_pulse got hit=%b cycles=%0d want %b/%0d",
                     r_hit, r_hit_cycles, TLB_ON, int'(TLB_ON));
        end
        n_checks++;
        if (pte_reads !== (TLB_ON ? 0 : 3)) begin
            n_fail++;
            $display("FAIL hit_pte_reads got %0d want %0d", pte_reads, TLB_ON ? 0 : 3);
        end
        n_checks++;
        if (r_req1.valid !== 1'b1
            || r_req1.addr !== (TLB_ON ? 64'h8020_0123 : 64'h8010_0810)) begin
            n_fail++;
            $display("FAIL hit_oreq_next got v=%b a=%h want v=1 a=%h", r_req1.valid,
                     r_req1.addr, TLB_ON ? 64'h8020_0123 : 64'h8010_0810);
        end
        n_checks++;
        if (r_data !== (64'h8020_0123 ^ K)) begin
            n_fail++;
            $display("FAIL hit_data got %h want %h", r_data, 64'h8020_0123 ^ K);
        end
    endtask

    task automatic test_sfence();
        @(posedge clk);
        #1;
        sfence = 1'b1;
        @(posedge clk);
        #1;
        sfence = 1'b0;
        do_req(VA1, PRIV_S);
        n_checks++;
        if (pte_reads !== 3 || r_hit !== 1'b0 || last_data_addr !== 64'h8020_0123) begin
            n_fail++;
            $display("FAIL sfence_rewalk got pte=%0d hit=%b pa=%h want 3/0/80200123",
                     pte_reads, r_hit, last_data_addr);
        end
    endtask

    task automatic test_fault();
        do_req(VA_BAD, PRIV_S);
        n_checks++;
        if (r_fault !== 1'b1 || r_data !== 64'h0) begin
            n_fail++;
            $display("FAIL fault_resp got pf=%b d=%h want 1/0", r_fault, r_data);
        end
        n_checks++;
        if (pte_reads !== 2 || data_reads !== 0) begin
            n_fail++;
            $display("FAIL fault_reads got pte=%0d data=%0d want 2/0", pte_reads, data_reads);
        end
        n_checks++;
        if (r_ready_after !== 1'b0 || r_pf_after !== 1'b0) begin
            n_fail++;
            $display("FAIL fault_width got ready=%b pf=%b want 0/0 next cycle",
                     r_ready_after, r_pf_after);
        end
    endtask

    task automatic test_round_robin();
        int misses;
        // reset while a walk is in flight: outputs must clear immediately
        @(posedge clk);
        #1;
        priv_mode = PRIV_S;
        ireq = '0;
        ireq.valid = 1'b1;
        ireq.addr = PAGE0 + 64'h3000;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_checks++;
        if (oreq.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midwalk_active got oreq.valid=%b want 1", oreq.valid);
        end
        ireq.valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (oreq.valid !== 1'b0 || iresp.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b r=%b want 0/0", oreq.valid, iresp.ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        misses = 0;
        for (int i = 0; i < 9; i++) begin
            do_req(PAGE0 + (64'(i) << 12), PRIV_S);
            if (pte_reads == 3 && last_data_addr == 64'h8020_0000 + (64'(i) << 12))
                misses++;
        end
        n_checks++;
        if (misses !== 9) begin
            n_fail++;
            $display("FAIL rr_fill got %0d clean walks want 9", misses);
        end
        do_req(PAGE0, PRIV_S);
        n_checks++;
        if (pte_reads !== 3 || r_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_evict_page0 got pte=%0d hit=%b want 3/0", pte_reads, r_hit);
        end
        do_req(PAGE0 + 64'h2000, PRIV_S);
        n_checks++;
        if (pte_reads !== (TLB_ON ? 0 : 3) || last_data_addr !== 64'h8020_2000) begin
            n_fail++;
            $display("FAIL rr_keep_page2 got pte=%0d pa=%h want %0d/80202000",
                     pte_reads, last_data_addr, TLB_ON ? 0 : 3);
        end
        do_req(PAGE0 + 64'h8000, PRIV_S);
        n_checks++;
        if (pte_reads !== (TLB_ON ? 0 : 3) || r_hit !== TLB_ON) begin
            n_fail++;
            $display("FAIL rr_keep_page8 got pte=%0d hit=%b want %0d/%b",
                     pte_reads, r_hit, TLB_ON ? 0 : 3, TLB_ON);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        sfence = 1'b0;
        ireq = '0;
        priv_mode = PRIV_S;
        satp = '0;
        satp.mode = 4'd8;
        satp.ppn = 44'h80100;
        test_reset();
        test_bare();
        test_cold_walk();
        test_tlb_hit();
        test_sfence();
        test_fault();
        test_round_robin();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end
endmodule
